// File: rtl/seg7_scan_reader.sv
// Receiver for the 6-digit multiplexed 7-segment scan bus: synchronises and
// stability-filters the lines, decodes each digit to BCD and publishes whole frames.
module seg7_scan_reader #(
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  seg_sel,
  input  logic [7:0]  seg_data,
  output logic [23:0] bcd_out,
  output logic [5:0]  dp_out,
  output logic        frame_valid,
  output logic [5:0]  frame_err,
  output logic        stale
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_SAT  = STAB_W'(STABLE_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  // Segment pattern (active-high, bits g..a) to {err, nibble}.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = {1'b0, 4'd0};
      7'h06:   res = {1'b0, 4'd1};
      7'h5B:   res = {1'b0, 4'd2};
      7'h4F:   res = {1'b0, 4'd3};
      7'h66:   res = {1'b0, 4'd4};
      7'h6D:   res = {1'b0, 4'd5};
      7'h7D:   res = {1'b0, 4'd6};
      7'h07:   res = {1'b0, 4'd7};
      7'h7F:   res = {1'b0, 4'd8};
      7'h6F:   res = {1'b0, 4'd9};
      default: res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  logic [5:0]        r_sel_p0, r_sel_p1, r_prev_sel;
  logic [7:0]        r_data_p0, r_data_p1, r_prev_data;
  logic [STAB_W-1:0] r_stab_cnt;

  state_t            r_state;
  logic [5:0]        r_mask;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_first_done;
  logic [23:0]       r_shd_bcd;
  logic [5:0]        r_shd_dp;
  logic [5:0]        r_shd_err;
  logic [23:0]       r_bcd;
  logic [5:0]        r_dp;
  logic [5:0]        r_err;
  logic              r_frame_valid;
  logic              r_stale;

  logic              w_same;
  logic              w_accept;
  logic [5:0]        w_dig_oh;
  logic              w_onehot;
  logic              w_acc_valid;
  logic [4:0]        w_dec;
  logic              w_dp;
  logic [5:0]        w_mask_nxt;
  logic [23:0]       w_shd_bcd_nxt;
  logic [5:0]        w_shd_dp_nxt;
  logic [5:0]        w_shd_err_nxt;

  // Stage p0/p1: two-flop synchroniser, then compare against previous value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_p0    <= '1;
      r_sel_p1    <= '1;
      r_data_p0   <= '1;
      r_data_p1   <= '1;
      r_prev_sel  <= '1;
      r_prev_data <= '1;
      r_stab_cnt  <= '0;
    end else begin
      r_sel_p0    <= seg_sel;
      r_sel_p1    <= r_sel_p0;
      r_data_p0   <= seg_data;
      r_data_p1   <= r_data_p0;
      r_prev_sel  <= r_sel_p1;
      r_prev_data <= r_data_p1;
      if (!w_same)
        r_stab_cnt <= '0;
      else if (r_stab_cnt != STAB_SAT)
        r_stab_cnt <= r_stab_cnt + 1'b1;
    end
  end

  assign w_same   = ({r_sel_p1, r_data_p1} == {r_prev_sel, r_prev_data});
  // Counter saturates one past the accept value, so each stable period fires once.
  assign w_accept = w_same && (r_stab_cnt == STAB_LAST);

  always_comb begin
    w_dig_oh = '0;
    for (int d = 0; d < 6; d++)
      w_dig_oh[d] = ~r_prev_sel[5-d];
  end

  assign w_onehot    = (w_dig_oh != 6'd0) && ((w_dig_oh & (w_dig_oh - 6'd1)) == 6'd0);
  assign w_acc_valid = w_accept && w_onehot;
  assign w_dec       = f_decode(~r_prev_data[6:0]);
  assign w_dp        = ~r_prev_data[7];
  assign w_mask_nxt  = r_mask | w_dig_oh;

  always_comb begin
    w_shd_bcd_nxt = r_shd_bcd;
    w_shd_dp_nxt  = r_shd_dp;
    w_shd_err_nxt = r_shd_err;
    for (int d = 0; d < 6; d++) begin
      if (w_dig_oh[d]) begin
        w_shd_bcd_nxt[4*d +: 4] = w_dec[3:0];
        w_shd_dp_nxt[d]         = w_dp;
        w_shd_err_nxt[d]        = w_dec[4];
      end
    end
  end

  // Stage p2: frame assembly FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mask        <= '0;
      r_tmo_cnt     <= '0;
      r_first_done  <= 1'b0;
      r_shd_bcd     <= '0;
      r_shd_dp      <= '0;
      r_shd_err     <= '0;
      r_bcd         <= '0;
      r_dp          <= '0;
      r_err         <= '0;
      r_frame_valid <= 1'b0;
      r_stale       <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_acc_valid) begin
        r_shd_bcd <= w_shd_bcd_nxt;
        r_shd_dp  <= w_shd_dp_nxt;
        r_shd_err <= w_shd_err_nxt;
      end
      case (r_state)
        S_IDLE: begin
          if (w_acc_valid) begin
            r_mask    <= w_dig_oh;
            r_tmo_cnt <= '0;
            r_state   <= S_COLLECT;
          end else if (r_first_done) begin
            if (r_tmo_cnt == TMO_LAST)
              r_stale <= 1'b1;
            else
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_COLLECT: begin
          if (w_acc_valid) begin
            r_tmo_cnt <= '0;
            if (w_mask_nxt == 6'h3F) begin
              // Outputs and the strobe land together, visible during PUBLISH.
              r_mask        <= '0;
              r_bcd         <= w_shd_bcd_nxt;
              r_dp          <= w_shd_dp_nxt;
              r_err         <= w_shd_err_nxt;
              r_frame_valid <= 1'b1;
              r_stale       <= 1'b0;
              r_first_done  <= 1'b1;
              r_state       <= S_PUBLISH;
            end else begin
              r_mask <= w_mask_nxt;
            end
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_mask    <= '0;
            r_stale   <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_PUBLISH: begin
          r_tmo_cnt <= '0;
          if (w_acc_valid)
            r_mask <= w_dig_oh;
          r_state <= S_COLLECT;
        end
        default: begin
          r_mask  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bcd_out     = r_bcd;
  assign dp_out      = r_dp;
  assign frame_err   = r_err;
  assign frame_valid = r_frame_valid;
  assign stale       = r_stale;

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receiver end of the team's 6-digit multiplexed 7-segment scan bus: samples the active-low digit-select and active-low segment/DP lines, and decodes each digit back to BCD.
- Assembles a complete 6-digit frame and presents it with a one-cycle valid strobe.
- Used for loopback self-check of the timer display path, and for reading external scanned displays.
- Inputs may come from a slower scan clock or off-chip, so they are synchronised and stability-filtered.

Parameters:
STABLE_CYCLES, 8, consecutive clk cycles a synchronised sel/data pair must hold before it is accepted (min 1)
TIMEOUT_CYCLES, 2048, clk cycles with no accepted digit before a partial frame is discarded and stale is raised

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  synchronous active-low reset
seg_sel  input  6  active-low digit select; bit0 = digit5 (most significant) ... bit5 = digit0 (least significant)
seg_data  input  8  active-low segments; bit0..6 = a..g, bit7 = DP (0 = lit)
bcd_out  output  24  decoded frame; [23:20] = digit5 ... [3:0] = digit0
dp_out  output  6  DP lit flags, same digit order as bcd_out nibbles (bit5 = digit5)
frame_valid  output  1  one-cycle pulse when bcd_out/dp_out/frame_err update
frame_err  output  6  per-digit flag: pattern not a decimal glyph
stale  output  1  high from timeout until the next frame_valid

Behaviour:
Reset and synchronisation:
- Reset (rst_n low at a clk edge) clears everything:
  - bcd_out = 24'h0, dp_out = 0, frame_err = 0, frame_valid = 0, stale = 0;
  - synchroniser flops set to 1 (idle bus);
  - stability and timeout counters = 0, received mask = 0, state = IDLE.
- Reset mid-frame discards the partial frame.
- seg_sel and seg_data each pass through a 2-flop synchroniser.
- A comparison register holds the previous synchronised value.

Stability filter:
- stab_cnt resets to 0 whenever the synchronised {sel,data} differs from the previous cycle; otherwise it increments, saturating.
- A sample is accepted on the cycle stab_cnt reaches STABLE_CYCLES-1, once per stable period.
- Re-arming requires a value change.
- Latency from an input change to acceptance is 2 + STABLE_CYCLES clk cycles.
- Accepted samples whose sel is not exactly one-hot-low (including 6'b111111 blank) are ignored: no mask or timer effect.

Decode (segment data inverted, then matched on bits 6:0):
- 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
- Any other pattern -> nibble 4'hF and the digit's err bit set.
- DP flag = ~seg_data[7].

State machine:
- IDLE:
  - the first accepted valid digit is written to the shadow registers (nibble, dp, err);
  - its mask bit is set and the timeout counter cleared;
  - go to COLLECT.
- COLLECT:
  - each accepted digit overwrites its shadow slot (a repeat of an already-received digit overwrites it), sets its mask bit, and clears the timeout counter;
  - when the mask becomes 6'b111111, go to PUBLISH;
  - if the timeout counter reaches TIMEOUT_CYCLES-1: clear the mask, set stale = 1, go to IDLE. Outputs are not updated.
- PUBLISH (one cycle):
  - copy the shadow registers to bcd_out/dp_out/frame_err;
  - pulse frame_valid;
  - clear stale and mask;
  - go to COLLECT with the timeout counter cleared.
  - frame_valid is high the cycle after the sixth distinct digit is accepted.
  - An acceptance arriving during the PUBLISH cycle is applied to the new frame's mask/shadow.
- Timeout is also counted in IDLE after the first frame:
  - when it reaches TIMEOUT_CYCLES-1, stale is set and the counter holds;
  - before the first frame, stale stays 0.
- Outputs hold between frames.
- Timeout and acceptance in the same cycle: acceptance wins; the counter clears and no stale is raised.

Test Plan:
- Reset, then drive a 6-digit scan showing "123456": sel 111110/F9, 111101/A4, 111011/B0, 110111/99, 101111/92, 011111/82, each held 125 clk -> one frame_valid, bcd_out=24'h123456, dp_out=0, frame_err=0, stale=0.
- Same scan with digit5 data 8'h79 (DP lit) -> dp_out=6'b100000, bcd_out=24'h123456.
- Digit2 data 8'hFF (blank) -> bcd_out=24'h123F56, frame_err=6'b000100.
- Glitch: digit0 data pulses 8'h88 for 3 clk inside its 125-clk slot -> rejected; only the settled 8'h82 decoded, bcd_out[3:0]=6.
- Stop the scan after 4 digits, wait TIMEOUT_CYCLES -> stale=1, no frame_valid, outputs unchanged; resume full scan -> frame_valid, stale=0.
- Assert rst_n=0 mid-frame for 1 clk, then a full scan -> exactly one frame_valid, only after all 6 digits are re-received; sel=111111 slots between digits do not affect assembly.
